// File: rtl/vram_arbiter_if.sv
// Writer-side handshake bundle for the VRAM arbiter: two independent
// valid/ready write channels (A and B) carrying a framebuffer address and pixel data.
interface vram_arbiter_if;
    logic        a_valid_in;
    logic [15:0] a_addr_in;
    logic [15:0] a_data_in;
    logic        a_ready_out;

    logic        b_valid_in;
    logic [15:0] b_addr_in;
    logic [15:0] b_data_in;
    logic        b_ready_out;

    modport master (
        output a_valid_in, a_addr_in, a_data_in,
        output b_valid_in, b_addr_in, b_data_in,
        input  a_ready_out, b_ready_out
    );

    modport slave (
        input  a_valid_in, a_addr_in, a_data_in,
        input  b_valid_in, b_addr_in, b_data_in,
        output a_ready_out, b_ready_out
    );
endinterface

// File: rtl/vram_arbiter.sv
// Shares a single-port framebuffer RAM between video scan-out and two writers.
// Writes are granted only while the raster is in blanking, with round-robin tie-breaking.
module vram_arbiter #(
    parameter int H_ACTIVE = 1280,
    parameter int H_TOTAL  = 1650,
    parameter int V_ACTIVE = 720,
    parameter int V_TOTAL  = 750,
    parameter int GUARD    = 2,
    parameter int FB_WIDTH = 320
) (
    input  logic        clk_pixel_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        nf_in,
    vram_arbiter_if.slave wr,
    output logic [15:0] mem_addr_out,
    output logic [15:0] mem_data_out,
    output logic        mem_we_out,
    output logic [15:0] frame_writes_out
);

    localparam logic [10:0] H_ACT       = 11'(H_ACTIVE);
    localparam logic [10:0] H_GUARD_BEG = 11'(H_TOTAL - GUARD);
    localparam logic [9:0]  V_ACT       = 10'(V_ACTIVE);
    localparam logic [9:0]  V_ACT_M1    = 10'(V_ACTIVE - 1);
    localparam logic [9:0]  V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [15:0] FB_W        = 16'(FB_WIDTH);

    typedef enum logic {
        DISP = 1'b0,
        OPEN = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        window;
    logic [15:0] disp_addr;
    logic        a_ready, b_ready;
    logic        a_xfer, b_xfer, xfer;

    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_data_q, mem_data_d;
    logic        last_b_q, last_b_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] cnt_after;
    logic [15:0] frame_writes_q, frame_writes_d;

    // The guard band closes the window just before a line that will carry active video.
    always_comb begin
        window = (hcount_in >= H_ACT) || (vcount_in >= V_ACT);
        if ((hcount_in >= H_GUARD_BEG) &&
            ((vcount_in < V_ACT_M1) || (vcount_in == V_LAST))) begin
            window = 1'b0;
        end
    end

    // Scan-out address: the framebuffer is the screen downscaled by 4 in both axes.
    assign disp_addr = {8'd0, vcount_in[9:2]} * FB_W + {7'd0, hcount_in[10:2]};

    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            state_q <= DISP;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = window ? OPEN : DISP;
    end

    // Ready also needs the live window so a closing window blocks writes immediately.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!rst_in && (state_q == OPEN) && window) begin
            if (wr.a_valid_in && wr.b_valid_in) begin
                if (last_b_q) begin
                    a_ready = 1'b1;
                end else begin
                    b_ready = 1'b1;
                end
            end else if (wr.a_valid_in) begin
                a_ready = 1'b1;
            end else if (wr.b_valid_in) begin
                b_ready = 1'b1;
            end
        end
    end

    assign wr.a_ready_out = a_ready;
    assign wr.b_ready_out = b_ready;
    assign a_xfer         = wr.a_valid_in & a_ready;
    assign b_xfer         = wr.b_valid_in & b_ready;
    assign xfer           = a_xfer | b_xfer;

    always_comb begin
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        last_b_d   = last_b_q;
        if (state_q == DISP) begin
            mem_addr_d = disp_addr;
        end else if (a_xfer) begin
            mem_we_d   = 1'b1;
            mem_addr_d = wr.a_addr_in;
            mem_data_d = wr.a_data_in;
            last_b_d   = 1'b0;
        end else if (b_xfer) begin
            mem_we_d   = 1'b1;
            mem_addr_d = wr.b_addr_in;
            mem_data_d = wr.b_data_in;
            last_b_d   = 1'b1;
        end
    end

    // The frame snapshot includes a write granted in the same cycle as the new-frame pulse.
    always_comb begin
        cnt_after      = cnt_q;
        cnt_d          = cnt_q;
        frame_writes_d = frame_writes_q;
        if (xfer && (cnt_q != 16'hFFFF)) begin
            cnt_after = cnt_q + 16'd1;
        end
        if (nf_in) begin
            frame_writes_d = cnt_after;
            cnt_d          = xfer ? 16'd1 : 16'd0;
        end else begin
            cnt_d = cnt_after;
        end
    end

    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            mem_we_q       <= 1'b0;
            mem_addr_q     <= 16'd0;
            mem_data_q     <= 16'd0;
            last_b_q       <= 1'b1;
            cnt_q          <= 16'd0;
            frame_writes_q <= 16'd0;
        end else begin
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_data_q     <= mem_data_d;
            last_b_q       <= last_b_d;
            cnt_q          <= cnt_d;
            frame_writes_q <= frame_writes_d;
        end
    end

    assign mem_we_out       = mem_we_q;
    assign mem_addr_out     = mem_addr_q;
    assign mem_data_out     = mem_data_q;
    assign frame_writes_out = frame_writes_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed vector table, a round-robin
// sequence after reset, and randomized traffic against a behavioural model.
module tb_vram_arbiter;

    localparam int H_ACTIVE = 1280;
    localparam int H_TOTAL  = 1650;
    localparam int V_ACTIVE = 720;
    localparam int V_TOTAL  = 750;
    localparam int GUARD    = 2;
    localparam int FB_WIDTH = 320;

    logic        clk;
    logic        rst;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        nf;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_we;
    logic [15:0] frame_writes;

    vram_arbiter_if wr_if ();

    vram_arbiter #(
        .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL), .V_ACTIVE(V_ACTIVE),
        .V_TOTAL(V_TOTAL), .GUARD(GUARD), .FB_WIDTH(FB_WIDTH)
    ) dut (
        .clk_pixel_in    (clk),
        .rst_in          (rst),
        .hcount_in       (hcount),
        .vcount_in       (vcount),
        .nf_in           (nf),
        .wr              (wr_if.slave),
        .mem_addr_out    (mem_addr),
        .mem_data_out    (mem_data),
        .mem_we_out      (mem_we),
        .frame_writes_out(frame_writes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic        rst;
        logic [10:0] h;
        logic [9:0]  v;
        logic        nf;
        logic        av;
        logic [15:0] aa;
        logic [15:0] ad;
        logic        bv;
        logic [15:0] ba;
        logic [15:0] bd;
        logic        ear;
        logic        ebr;
        logic        ewe;
        logic [15:0] eaddr;
        logic [15:0] edata;
        logic [15:0] efw;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model state
    bit m_open;
    bit m_last_b;
    int m_cnt;
    int m_fw;
    bit m_we;
    int m_addr;
    int m_data;

    function automatic bit win(int h, int v);
        bit open_region = (h >= H_ACTIVE) || (v >= V_ACTIVE);
        bit guard = (h >= H_TOTAL - GUARD) && ((v < V_ACTIVE - 1) || (v == V_TOTAL - 1));
        return open_region && !guard;
    endfunction

    function automatic vec_t mk(logic r, int h, int v, logic n,
                                logic av, logic [15:0] aa, logic [15:0] ad,
                                logic bv, logic [15:0] ba, logic [15:0] bd,
                                logic ear, logic ebr, logic ewe,
                                logic [15:0] eaddr, logic [15:0] edata, logic [15:0] efw);
        vec_t t;
        t.rst = r;   t.h = 11'(h);  t.v = 10'(v);  t.nf = n;
        t.av = av;   t.aa = aa;     t.ad = ad;
        t.bv = bv;   t.ba = ba;     t.bd = bd;
        t.ear = ear; t.ebr = ebr;   t.ewe = ewe;
        t.eaddr = eaddr; t.edata = edata; t.efw = efw;
        return t;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t t);
        rst    = t.rst;
        hcount = t.h;
        vcount = t.v;
        nf     = t.nf;
        wr_if.a_valid_in = t.av;
        wr_if.a_addr_in  = t.aa;
        wr_if.a_data_in  = t.ad;
        wr_if.b_valid_in = t.bv;
        wr_if.b_addr_in  = t.ba;
        wr_if.b_data_in  = t.bd;
    endtask

    // Called just after a falling edge with inputs applied; returns after the next falling edge.
    task automatic check_output(input string tag, input bit ear, input bit ebr, input bit ewe,
                                input logic [15:0] eaddr, input logic [15:0] edata,
                                input logic [15:0] efw);
        #1;
        check({tag, ".a_ready"}, 16'(wr_if.a_ready_out), 16'(ear));
        check({tag, ".b_ready"}, 16'(wr_if.b_ready_out), 16'(ebr));
        @(posedge clk);
        #1;
        check({tag, ".mem_we"}, 16'(mem_we), 16'(ewe));
        check({tag, ".mem_addr"}, mem_addr, eaddr);
        check({tag, ".mem_data"}, mem_data, edata);
        check({tag, ".frame_writes"}, frame_writes, efw);
        @(negedge clk);
    endtask

    task automatic model_ready(output bit ar, output bit br);
        ar = 1'b0;
        br = 1'b0;
        if (!rst && m_open && win(int'(hcount), int'(vcount))) begin
            if (wr_if.a_valid_in && wr_if.b_valid_in) begin
                if (m_last_b) ar = 1'b1;
                else          br = 1'b1;
            end else if (wr_if.a_valid_in) begin
                ar = 1'b1;
            end else if (wr_if.b_valid_in) begin
                br = 1'b1;
            end
        end
    endtask

    task automatic model_commit(input bit ar, input bit br);
        int counted;
        bit xfer;
        if (rst) begin
            m_open = 0; m_we = 0; m_addr = 0; m_data = 0;
            m_cnt = 0;  m_fw = 0; m_last_b = 1;
        end else begin
            xfer = ar || br;
            m_we = 0;
            if (!m_open) begin
                m_addr = ((int'(vcount) / 4) * FB_WIDTH + int'(hcount) / 4) % 65536;
            end else if (ar) begin
                m_we = 1; m_addr = int'(wr_if.a_addr_in); m_data = int'(wr_if.a_data_in);
                m_last_b = 0;
            end else if (br) begin
                m_we = 1; m_addr = int'(wr_if.b_addr_in); m_data = int'(wr_if.b_data_in);
                m_last_b = 1;
            end
            counted = xfer ? ((m_cnt + 1 > 65535) ? 65535 : m_cnt + 1) : m_cnt;
            if (nf) begin
                m_fw  = counted;
                m_cnt = xfer ? 1 : 0;
            end else begin
                m_cnt = counted;
            end
            m_open = win(int'(hcount), int'(vcount));
        end
    endtask

    initial begin
        bit ar, br;
        bit a_pend, b_pend;
        int hold;
        bit exp_a;

        rst = 1'b1; hcount = '0; vcount = '0; nf = 1'b0;
        wr_if.a_valid_in = 1'b0; wr_if.a_addr_in = '0; wr_if.a_data_in = '0;
        wr_if.b_valid_in = 1'b0; wr_if.b_addr_in = '0; wr_if.b_data_in = '0;

        //        rst  h     v    nf  av aa       ad       bv ba       bd       ar br we addr     data     fw
        tbl.push_back(mk(1, 0,    0,   0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'd0));
        tbl.push_back(mk(0, 100,  8,   0, 1, 16'h0123, 16'hBEEF, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'd665,  16'h0000, 16'd0));
        tbl.push_back(mk(0, 1300, 10,  0, 1, 16'h0123, 16'hBEEF, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'd965,  16'h0000, 16'd0));
        tbl.push_back(mk(0, 1300, 10,  0, 1, 16'h0123, 16'hBEEF, 0, 16'h0000, 16'h0000, 1, 0, 1, 16'h0123, 16'hBEEF, 16'd0));
        tbl.push_back(mk(0, 1301, 10,  0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0123, 16'hBEEF, 16'd0));
        tbl.push_back(mk(0, 1302, 10,  0, 1, 16'h1000, 16'h1111, 1, 16'h2000, 16'h2222, 0, 1, 1, 16'h2000, 16'h2222, 16'd0));
        tbl.push_back(mk(0, 1303, 10,  0, 1, 16'h1000, 16'h1111, 1, 16'h2001, 16'h2223, 1, 0, 1, 16'h1000, 16'h1111, 16'd0));
        tbl.push_back(mk(0, 1304, 10,  0, 0, 16'h0000, 16'h0000, 1, 16'h2001, 16'h2223, 0, 1, 1, 16'h2001, 16'h2223, 16'd0));
        tbl.push_back(mk(0, 1648, 5,   0, 0, 16'h0000, 16'h0000, 1, 16'h2002, 16'h2224, 0, 0, 0, 16'h2001, 16'h2223, 16'd0));
        tbl.push_back(mk(0, 1648, 730, 0, 0, 16'h0000, 16'h0000, 1, 16'h2002, 16'h2224, 0, 0, 0, 16'd58652, 16'h2223, 16'd0));
        tbl.push_back(mk(0, 1648, 730, 0, 0, 16'h0000, 16'h0000, 1, 16'h2002, 16'h2224, 0, 1, 1, 16'h2002, 16'h2224, 16'd0));
        tbl.push_back(mk(0, 1649, 749, 0, 1, 16'h3000, 16'h3333, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h2002, 16'h2224, 16'd0));
        tbl.push_back(mk(0, 1400, 749, 0, 1, 16'h3000, 16'h3333, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'd60190, 16'h2224, 16'd0));
        tbl.push_back(mk(0, 1400, 749, 0, 1, 16'h3000, 16'h3333, 0, 16'h0000, 16'h0000, 1, 0, 1, 16'h3000, 16'h3333, 16'd0));
        tbl.push_back(mk(0, 1401, 749, 0, 0, 16'h0000, 16'h0000, 1, 16'h4000, 16'h4444, 0, 1, 1, 16'h4000, 16'h4444, 16'd0));
        tbl.push_back(mk(0, 1402, 749, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h4000, 16'h4444, 16'd7));
        tbl.push_back(mk(0, 1403, 749, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h4000, 16'h4444, 16'd7));
        tbl.push_back(mk(0, 1404, 749, 1, 1, 16'h5000, 16'h5555, 0, 16'h0000, 16'h0000, 1, 0, 1, 16'h5000, 16'h5555, 16'd1));
        tbl.push_back(mk(0, 1405, 749, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h5000, 16'h5555, 16'd1));
        tbl.push_back(mk(0, 1406, 749, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h5000, 16'h5555, 16'd0));
        tbl.push_back(mk(1, 1406, 749, 0, 1, 16'h6000, 16'h6666, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'd0));
        tbl.push_back(mk(0, 1407, 10,  0, 1, 16'h6000, 16'h6666, 1, 16'h7000, 16'h7777, 0, 0, 0, 16'd991,  16'h0000, 16'd0));
        tbl.push_back(mk(0, 1407, 10,  0, 1, 16'h6000, 16'h6666, 1, 16'h7000, 16'h7777, 1, 0, 1, 16'h6000, 16'h6666, 16'd0));
        tbl.push_back(mk(0, 1408, 10,  0, 0, 16'h0000, 16'h0000, 1, 16'h7000, 16'h7777, 0, 1, 1, 16'h7000, 16'h7777, 16'd0));

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            apply_stimulus(tbl[i]);
            check_output($sformatf("vec%0d", i), tbl[i].ear, tbl[i].ebr, tbl[i].ewe,
                         tbl[i].eaddr, tbl[i].edata, tbl[i].efw);
        end

        // Round-robin after reset: both writers keep requesting, grants alternate from A.
        rst = 1'b1; nf = 1'b0; hcount = 11'd1300; vcount = 10'd10;
        wr_if.a_valid_in = 1'b1; wr_if.a_addr_in = 16'hAAAA; wr_if.a_data_in = 16'h0A0A;
        wr_if.b_valid_in = 1'b1; wr_if.b_addr_in = 16'hBBBB; wr_if.b_data_in = 16'h0B0B;
        check_output("rr_reset", 0, 0, 0, 16'h0000, 16'h0000, 16'd0);
        rst = 1'b0;
        check_output("rr_disp", 0, 0, 0, 16'd965, 16'h0000, 16'd0);
        for (int i = 0; i < 4; i++) begin
            exp_a = (i % 2 == 0);
            check_output($sformatf("rr%0d", i), exp_a, !exp_a, 1'b1,
                         exp_a ? 16'hAAAA : 16'hBBBB, exp_a ? 16'h0A0A : 16'h0B0B, 16'd0);
        end

        // Randomized traffic against the behavioural model.
        rst = 1'b1; nf = 1'b0;
        wr_if.a_valid_in = 1'b0; wr_if.b_valid_in = 1'b0;
        model_ready(ar, br);
        model_commit(ar, br);
        check_output("rnd_reset", 0, 0, 0, 16'h0000, 16'h0000, 16'd0);
        a_pend = 0; b_pend = 0; hold = 0;
        for (int i = 0; i < 600; i++) begin
            if (hold == 0) begin
                case ($urandom_range(0, 3))
                    0: hcount = 11'($urandom_range(0, H_ACTIVE - 1));
                    1: hcount = 11'($urandom_range(H_ACTIVE, H_TOTAL - GUARD - 1));
                    2: hcount = 11'($urandom_range(H_TOTAL - GUARD - 2, H_TOTAL - 1));
                    default: hcount = 11'($urandom_range(0, H_TOTAL - 1));
                endcase
                case ($urandom_range(0, 2))
                    0: vcount = 10'($urandom_range(0, V_TOTAL - 1));
                    1: vcount = 10'($urandom_range(V_ACTIVE - 2, V_ACTIVE + 1));
                    default: vcount = 10'($urandom_range(V_TOTAL - 2, V_TOTAL - 1));
                endcase
                hold = $urandom_range(1, 4);
            end
            hold--;
            rst = ($urandom_range(0, 99) == 0);
            nf  = ($urandom_range(0, 19) == 0);
            if (!a_pend && $urandom_range(0, 1) == 1) begin
                a_pend = 1;
                wr_if.a_addr_in = 16'($urandom);
                wr_if.a_data_in = 16'($urandom);
            end
            if (!b_pend && $urandom_range(0, 1) == 1) begin
                b_pend = 1;
                wr_if.b_addr_in = 16'($urandom);
                wr_if.b_data_in = 16'($urandom);
            end
            wr_if.a_valid_in = a_pend;
            wr_if.b_valid_in = b_pend;
            model_ready(ar, br);
            if (ar && br) begin
                tests_failed++;
                $display("[TB] FAIL model_dual_grant: got both, expected one");
            end
            model_commit(ar, br);
            check_output($sformatf("rnd%0d", i), ar, br, m_we, 16'(m_addr), 16'(m_data), 16'(m_fw));
            if (ar) a_pend = 0;
            if (br) b_pend = 0;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "[TB] timeout");
    end

endmodule
